// File: rtl/fu_sequencer.sv
// Micro-sequencer: fetches 20-bit program words, drives the combinational FU and writes
// its result back into a 4x8 register file. The host loads registers and starts runs.
module fu_sequencer #(
  parameter int unsigned PROG_AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic [PROG_AW-1:0] prog_addr_o,
  input  logic [19:0]        prog_data_i,
  input  logic               rf_we_i,
  input  logic [1:0]         rf_waddr_i,
  input  logic [7:0]         rf_wdata_i,
  input  logic [1:0]         rf_raddr_i,
  output logic [7:0]         rf_rdata_o,
  output logic [7:0]         fu_instruction_o,
  output logic [2:0]         fu_select_o,
  output logic [7:0]         fu_a_o,
  output logic [7:0]         fu_b_o,
  output logic [7:0]         fu_c_o,
  input  logic [7:0]         fu_f_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         step_count_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StWrite, StDone} state_e;

  localparam logic [PROG_AW-1:0] PcMax = '1;

  state_e             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic [PROG_AW-1:0] addr_q, addr_d;
  logic [19:0]        ir_q, ir_d;
  logic [7:0]         step_q, step_d;
  logic [7:0]         rf_q [4];
  logic [7:0]         rf_d [4];

  logic [7:0] ir_instr;
  logic [2:0] ir_sel;
  logic [1:0] ir_src_a, ir_src_b, ir_src_c, ir_dst;
  logic       ir_halt;

  assign ir_instr = ir_q[19:12];
  assign ir_sel   = ir_q[11:9];
  assign ir_src_a = ir_q[8:7];
  assign ir_src_b = ir_q[6:5];
  assign ir_src_c = ir_q[4:3];
  assign ir_dst   = ir_q[2:1];
  assign ir_halt  = ir_q[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    step_d  = step_q;
    rf_d    = rf_q;
    unique case (state_q)
      StIdle: begin
        // A host write in the start cycle still lands before the run reads it.
        if (rf_we_i) rf_d[rf_waddr_i] = rf_wdata_i;
        if (start_i) begin
          pc_d    = '0;
          addr_d  = '0;
          step_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_d    = prog_data_i;
        state_d = StExec;
      end
      StExec: state_d = StWrite;
      StWrite: begin
        rf_d[ir_dst] = fu_f_i;
        if (step_q != 8'hff) step_d = step_q + 8'd1;
        // pc saturates at the last word so a run can never wrap back to 0.
        if (pc_q != PcMax) pc_d = pc_q + 1'b1;
        if (ir_halt || pc_q == PcMax) begin
          state_d = StDone;
        end else begin
          addr_d  = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      step_q  <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    fu_instruction_o = '0;
    fu_select_o      = '0;
    fu_a_o           = '0;
    fu_b_o           = '0;
    fu_c_o           = '0;
    if (state_q == StExec || state_q == StWrite) begin
      fu_instruction_o = ir_instr;
      fu_select_o      = ir_sel;
      fu_a_o           = rf_q[ir_src_a];
      fu_b_o           = rf_q[ir_src_b];
      fu_c_o           = rf_q[ir_src_c];
    end
  end

  assign prog_addr_o  = addr_q;
  assign rf_rdata_o   = rf_q[rf_raddr_i];
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign step_count_o = step_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// Randomised bench for fu_sequencer: program ROM and FU stub (F = A + B + C + instr) live
// here, and a word-by-word reference model predicts registers, timing and FU operands.
module tb_fu_sequencer;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, rf_we;
  logic [AW-1:0] prog_addr;
  logic [19:0]   prog_data;
  logic [1:0]    rf_waddr, rf_raddr;
  logic [7:0]    rf_wdata, rf_rdata;
  logic [7:0]    fu_instruction, fu_a, fu_b, fu_c, fu_f;
  logic [2:0]    fu_select;
  logic          busy, done;
  logic [7:0]    step_count;

  logic [19:0] rom [16];
  logic [7:0]  m_rf [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign prog_data = rom[prog_addr];
  assign fu_f      = fu_a + fu_b + fu_c + fu_instruction;

  fu_sequencer #(.PROG_AW(AW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .prog_addr_o     (prog_addr),
    .prog_data_i     (prog_data),
    .rf_we_i         (rf_we),
    .rf_waddr_i      (rf_waddr),
    .rf_wdata_i      (rf_wdata),
    .rf_raddr_i      (rf_raddr),
    .rf_rdata_o      (rf_rdata),
    .fu_instruction_o(fu_instruction),
    .fu_select_o     (fu_select),
    .fu_a_o          (fu_a),
    .fu_b_o          (fu_b),
    .fu_c_o          (fu_c),
    .fu_f_i          (fu_f),
    .busy_o          (busy),
    .done_o          (done),
    .step_count_o    (step_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [7:0] instr, input logic [2:0] sel,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic [1:0] d,
                                     input logic h);
    return {instr, sel, a, b, c, d, h};
  endfunction

  function automatic logic [42:0] fu_vec();
    return {fu_instruction, fu_select, fu_a, fu_b, fu_c};
  endfunction

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(negedge clk);
    rf_we = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      rf_raddr = 2'(i);
      #1;
      check(tag, rf_rdata, m_rf[i]);
    end
  endtask

  // Runs the loaded ROM; k counts negedges after the edge that samples start.
  task automatic run_prog(input bit disturb, input bit wr_at_start,
                          input logic [1:0] wa, input logic [7:0] wd, output int n);
    logic [42:0] exp_fu [16];
    logic [19:0] w;
    logic [7:0]  a, b, c;
    logic [42:0] e;
    if (wr_at_start) m_rf[wa] = wd;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      w = rom[i];
      a = m_rf[w[8:7]]; b = m_rf[w[6:5]]; c = m_rf[w[4:3]];
      exp_fu[i] = {w[19:12], w[11:9], a, b, c};
      m_rf[w[2:1]] = a + b + c + w[19:12];
      n = i + 1;
      if (w[0]) break;
    end
    @(negedge clk);
    start = 1'b1;
    if (wr_at_start) begin
      rf_we = 1'b1; rf_waddr = wa; rf_wdata = wd;
    end
    @(negedge clk);
    start = 1'b0; rf_we = 1'b0;
    for (int k = 1; k <= 3 * n + 2; k++) begin
      e = '0;
      if (k <= 3 * n && (k - 1) % 3 != 0) e = exp_fu[(k - 1) / 3];
      check("fu_out", fu_vec(), e);
      check("busy", busy, (k <= 3 * n + 1));
      check("done", done, (k == 3 * n + 1));
      if (disturb && k <= 3 * n + 1) begin
        start    = 1'($urandom_range(0, 1));
        rf_we    = 1'($urandom_range(0, 1));
        rf_waddr = 2'($urandom);
        rf_wdata = 8'($urandom);
      end else begin
        start = 1'b0; rf_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; rf_we = 1'b0;
    check("step_count", step_count, 8'(n));
    check_rf("rf_after_run");
  endtask

  initial begin
    int n;
    logic [19:0] w;
    rst = 1'b1; start = 1'b0; rf_we = 1'b0;
    rf_waddr = '0; rf_wdata = '0; rf_raddr = '0;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_step", step_count, 8'd0);
    check("rst_addr", prog_addr, '0);
    check("rst_fu", fu_vec(), '0);
    check_rf("rst_rf");

    // Host load and read-back.
    for (int i = 0; i < 4; i++) host_write(2'(i), 8'(i + 1));
    check_rf("host_rf");

    // Single halting word: rf3 = 1 + 2 + 3 + 0.
    rom[0] = mk(8'h00, 3'd0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
    run_prog(1'b0, 1'b0, 2'd0, 8'd0, n);
    check("single_rf3", m_rf[3], 8'h06);

    // Three-word chain: each dst feeds the next srcA.
    rom[0] = mk(8'h10, 3'd1, 2'd0, 2'd1, 2'd1, 2'd2, 1'b0);
    rom[1] = mk(8'h20, 3'd2, 2'd2, 2'd3, 2'd0, 2'd1, 1'b0);
    rom[2] = mk(8'h05, 3'd3, 2'd1, 2'd0, 2'd2, 2'd0, 1'b1);
    run_prog(1'b0, 1'b0, 2'd0, 8'd0, n);
    check("chain_len", n, 3);

    // Full 16-word program with no halt: stops at the last word, no wrap.
    for (int i = 0; i < 16; i++) begin
      w = 20'($urandom);
      rom[i] = {w[19:1], 1'b0};
    end
    run_prog(1'b0, 1'b0, 2'd0, 8'd0, n);
    check("full_len", n, 16);
    check("full_addr", prog_addr, 4'hf);

    // Random programs, some disturbed by start/rf_we while busy, some with write+start.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) begin
        w = 20'($urandom);
        rom[i] = {w[19:1], ($urandom_range(0, 3) == 0)};
      end
      run_prog(t[0], t[1], 2'($urandom), 8'($urandom), n);
    end

    // Reset during EXEC of word 1.
    for (int i = 0; i < 16; i++) rom[i] = mk(8'($urandom), 3'd0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
    host_write(2'd0, 8'h55);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_fu", fu_instruction, rom[1][19:12]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_step", step_count, 8'd0);
    check("mid_rst_fu", fu_vec(), '0);
    check_rf("mid_rst_rf");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("no_done_after_rst", {busy, done}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
